// File: rtl/vga_timing_pkg.sv
// Shared mode constants, total computation and CD bus layout for the VGA/HDMI timing path.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int unsigned VGA640_H_VISIBLE = 640;
    localparam int unsigned VGA640_H_FRONT   = 16;
    localparam int unsigned VGA640_H_SYNC    = 96;
    localparam int unsigned VGA640_H_BACK    = 48;
    localparam int unsigned VGA640_V_VISIBLE = 480;
    localparam int unsigned VGA640_V_FRONT   = 10;
    localparam int unsigned VGA640_V_SYNC    = 2;
    localparam int unsigned VGA640_V_BACK    = 33;
    localparam bit          VGA640_H_POL     = 1'b0;
    localparam bit          VGA640_V_POL     = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int unsigned SVGA800_H_VISIBLE = 800;
    localparam int unsigned SVGA800_H_FRONT   = 40;
    localparam int unsigned SVGA800_H_SYNC    = 128;
    localparam int unsigned SVGA800_H_BACK    = 88;
    localparam int unsigned SVGA800_V_VISIBLE = 600;
    localparam int unsigned SVGA800_V_FRONT   = 1;
    localparam int unsigned SVGA800_V_SYNC    = 4;
    localparam int unsigned SVGA800_V_BACK    = 23;
    localparam bit          SVGA800_H_POL     = 1'b1;
    localparam bit          SVGA800_V_POL     = 1'b1;

    localparam int unsigned CD_W = 2;

    // TMDS control-data pair as consumed by the encoders: {vsync, hsync}
    typedef struct packed {
        logic vsync;
        logic hsync;
    } cd_t;

    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter: loads MAX on reset, wraps MAX -> 0 when enabled.
module vga_axis_counter #(
    parameter int unsigned W   = 12,
    parameter int unsigned MAX = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next_c,
    output logic         tc_c
);

    always_comb begin
        tc_c         = (count == W'(MAX));
        count_next_c = count;
        if (reset) begin
            count_next_c = W'(MAX);
        end else if (en) begin
            count_next_c = tc_c ? '0 : count + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= W'(MAX);
        end else begin
            count <= count_next_c;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator feeding the TMDS encoders (VDE, CD) and the frame source (x, y).
// Define VGA_TIMING_TEST_PATTERN_EN to add an 8-bar colour test pattern on r/g/b.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = VGA640_H_VISIBLE,
    parameter int unsigned H_FRONT    = VGA640_H_FRONT,
    parameter int unsigned H_SYNC     = VGA640_H_SYNC,
    parameter int unsigned H_BACK     = VGA640_H_BACK,
    parameter int unsigned V_VISIBLE  = VGA640_V_VISIBLE,
    parameter int unsigned V_FRONT    = VGA640_V_FRONT,
    parameter int unsigned V_SYNC     = VGA640_V_SYNC,
    parameter int unsigned V_BACK     = VGA640_V_BACK,
    parameter bit          H_SYNC_POL = VGA640_H_POL,
    parameter bit          V_SYNC_POL = VGA640_V_POL,
    parameter int unsigned CNT_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [CD_W-1:0]  cd,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b
`endif
);

    localparam int unsigned H_TOTAL      = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL      = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    if (64'(H_TOTAL) > (64'(1) << CNT_W)) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             h_tc;
    logic             v_tc;

    vga_axis_counter #(.W(CNT_W), .MAX(H_TOTAL - 1)) u_h_cnt (
        .clk          (clk),
        .reset        (reset),
        .en           (1'b1),
        .count        (x),
        .count_next_c (x_nxt),
        .tc_c         (h_tc)
    );

    vga_axis_counter #(.W(CNT_W), .MAX(V_TOTAL - 1)) u_v_cnt (
        .clk          (clk),
        .reset        (reset),
        .en           (h_tc),
        .count        (y),
        .count_next_c (y_nxt),
        .tc_c         (v_tc)
    );

    // Decode the coming position so every registered output lines up with x/y.
    logic de_nxt;
    logic hsync_nxt;
    logic vsync_nxt;
    logic line_start_nxt;
    logic frame_start_nxt;

    always_comb begin
        de_nxt          = (x_nxt < CNT_W'(H_VISIBLE)) && (y_nxt < CNT_W'(V_VISIBLE));
        hsync_nxt       = ~H_SYNC_POL;
        vsync_nxt       = ~V_SYNC_POL;
        line_start_nxt  = h_tc && !reset;
        frame_start_nxt = h_tc && v_tc && !reset;
        if ((x_nxt >= CNT_W'(H_SYNC_START)) && (x_nxt < CNT_W'(H_SYNC_END))) begin
            hsync_nxt = H_SYNC_POL;
        end
        if ((y_nxt >= CNT_W'(V_SYNC_START)) && (y_nxt < CNT_W'(V_SYNC_END))) begin
            vsync_nxt = V_SYNC_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de          <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            cd          <= cd_t'{vsync: ~V_SYNC_POL, hsync: ~H_SYNC_POL};
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= de_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            cd          <= cd_t'{vsync: vsync_nxt, hsync: hsync_nxt};
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_VISIBLE / 8;

    logic [2:0] bar_nxt;

    always_comb begin
        bar_nxt = 3'd0;
        if (de_nxt) begin
            bar_nxt = 3'(x_nxt / CNT_W'(BAR_W));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !de_nxt) begin
            r <= 8'h00;
            g <= 8'h00;
            b <= 8'h00;
        end else begin
            r <= {8{bar_nxt[2]}};
            g <= {8{bar_nxt[1]}};
            b <= {8{bar_nxt[0]}};
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny mode for full-frame checks.
module tb_vga_timing_gen;

    logic clk;
    logic reset;
    logic reset_s;

    logic [11:0] x, y;
    logic de, hs, vs, ls, fs;
    logic [1:0] cd;

    logic [4:0] sx, sy;
    logic sde, shs, svs, sls, sfs;
    logic [1:0] scd;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [7:0] r, g, b;
    logic [7:0] sr, sg, sb;
`endif

    vga_timing_gen dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .de          (de),
        .hsync       (hs),
        .vsync       (vs),
        .cd          (cd),
        .line_start  (ls),
        .frame_start (fs)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .r           (r),
        .g           (g),
        .b           (b)
`endif
    );

    // 24x10 mode with active-high syncs: frame = 240 cycles
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(5)
    ) dut_s (
        .clk         (clk),
        .reset       (reset_s),
        .x           (sx),
        .y           (sy),
        .de          (sde),
        .hsync       (shs),
        .vsync       (svs),
        .cd          (scd),
        .line_start  (sls),
        .frame_start (sfs)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .r           (sr),
        .g           (sg),
        .b           (sb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        int   n;
        int   ex;
        int   ey;
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl[12];

`ifdef VGA_TIMING_TEST_PATTERN_EN
    typedef struct {
        int          px;
        logic [23:0] rgb;
    } pat_t;
    pat_t ptbl[7];
`endif

    initial begin
        int de_cnt, hs_cnt, ls_cnt, fs_cnt, first_hs, period;
        int sde_cnt, shs_cnt, svs_cnt, sls_cnt, vs_x, vs_y;
        logic prev_vs;

        // n = cycles after reset release; x,y,de,hsync,vsync,line_start,frame_start
        tbl[0]  = '{1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{2,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{640,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{641,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{656,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{657,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{752,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{753,  752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{800,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{801,  0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{4800, 799, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4801, 0,   6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset   = 1'b1;
        reset_s = 1'b1;
        repeat (3) step();

        chk("rst.x",  32'(x),  32'd799);
        chk("rst.y",  32'(y),  32'd524);
        chk("rst.de", 32'(de), 32'd0);
        chk("rst.hs", 32'(hs), 32'd1);
        chk("rst.vs", 32'(vs), 32'd1);
        chk("rst.cd", 32'(cd), 32'd3);
        chk("rst.ls", 32'(ls), 32'd0);
        chk("rst.fs", 32'(fs), 32'd0);
        chk("hold_s.x", 32'(sx), 32'd23);
        chk("hold_s.y", 32'(sy), 32'd9);

        reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].n) step();
            chk($sformatf("v%0d.x", i),  32'(x),  32'(tbl[i].ex));
            chk($sformatf("v%0d.y", i),  32'(y),  32'(tbl[i].ey));
            chk($sformatf("v%0d.de", i), 32'(de), 32'(tbl[i].de));
            chk($sformatf("v%0d.hs", i), 32'(hs), 32'(tbl[i].hs));
            chk($sformatf("v%0d.vs", i), 32'(vs), 32'(tbl[i].vs));
            chk($sformatf("v%0d.cd", i), 32'(cd), 32'({tbl[i].vs, tbl[i].hs}));
            chk($sformatf("v%0d.ls", i), 32'(ls), 32'(tbl[i].ls));
            chk($sformatf("v%0d.fs", i), 32'(fs), 32'(tbl[i].fs));
        end

        // Whole line y=6, starting at x=0
        de_cnt = 0; hs_cnt = 0; ls_cnt = 0; fs_cnt = 0; first_hs = -1;
        for (int k = 0; k < 800; k++) begin
            if (k > 0) step();
            if (de) de_cnt++;
            if (!hs) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(x);
            end
            if (ls) ls_cnt++;
            if (fs) fs_cnt++;
        end
        chk("line.de_cnt",   32'(de_cnt),   32'd640);
        chk("line.hs_cnt",   32'(hs_cnt),   32'd96);
        chk("line.hs_first", 32'(first_hs), 32'd656);
        chk("line.ls_cnt",   32'(ls_cnt),   32'd1);
        chk("line.fs_cnt",   32'(fs_cnt),   32'd0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
        ptbl[0] = '{0,   24'h000000};
        ptbl[1] = '{79,  24'h000000};
        ptbl[2] = '{80,  24'h0000FF};
        ptbl[3] = '{320, 24'hFF0000};
        ptbl[4] = '{560, 24'hFFFFFF};
        ptbl[5] = '{639, 24'hFFFFFF};
        ptbl[6] = '{640, 24'h000000};
        for (int i = 0; i < 7; i++) begin
            while (cyc < 8001 + ptbl[i].px) step();
            chk($sformatf("pat%0d.x", i), 32'(x), 32'(ptbl[i].px));
            chk($sformatf("pat%0d.rgb", i), 32'({r, g, b}), 32'(ptbl[i].rgb));
        end
`endif

        // Mid-frame reset at x=300, y=11
        while (cyc < 9101) step();
        chk("mid.x", 32'(x), 32'd300);
        chk("mid.y", 32'(y), 32'd11);
        reset = 1'b1;
        step();
        chk("mid_rst.x",  32'(x),  32'd799);
        chk("mid_rst.y",  32'(y),  32'd524);
        chk("mid_rst.de", 32'(de), 32'd0);
        chk("mid_rst.cd", 32'(cd), 32'd3);
        chk("mid_rst.ls", 32'(ls), 32'd0);
        chk("mid_rst.fs", 32'(fs), 32'd0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        chk("mid_rst.rgb", 32'({r, g, b}), 32'h0);
`endif
        reset = 1'b0;
        step();
        chk("mid_rel.x",  32'(x),  32'd0);
        chk("mid_rel.y",  32'(y),  32'd0);
        chk("mid_rel.fs", 32'(fs), 32'd1);
        chk("mid_rel.ls", 32'(ls), 32'd1);
        step();
        chk("mid_rel2.x",  32'(x),  32'd1);
        chk("mid_rel2.fs", 32'(fs), 32'd0);

        // Small mode held in reset throughout so far
        chk("hold_s2.x",  32'(sx),  32'd23);
        chk("hold_s2.y",  32'(sy),  32'd9);
        chk("hold_s2.ls", 32'(sls), 32'd0);
        chk("hold_s2.fs", 32'(sfs), 32'd0);
        chk("hold_s2.cd", 32'(scd), 32'd0);

        reset_s = 1'b0;
        step();
        chk("s0.x",  32'(sx),  32'd0);
        chk("s0.y",  32'(sy),  32'd0);
        chk("s0.fs", 32'(sfs), 32'd1);
        chk("s0.hs", 32'(shs), 32'd0);
        chk("s0.vs", 32'(svs), 32'd0);

        sde_cnt = int'(sde); shs_cnt = int'(shs); svs_cnt = int'(svs); sls_cnt = int'(sls);
        prev_vs = svs; vs_x = -1; vs_y = -1; period = 0;
        for (int k = 1; k <= 300 && period == 0; k++) begin
            step();
`ifdef VGA_TIMING_TEST_PATTERN_EN
            if (k == 2) chk("s.rgb_bar1", 32'({sr, sg, sb}), 32'h0000FF);
`endif
            if (sfs) period = k;
            if (k < 240) begin
                if (sde) sde_cnt++;
                if (shs) shs_cnt++;
                if (svs) svs_cnt++;
                if (sls) sls_cnt++;
                if (svs && !prev_vs && vs_x < 0) begin
                    vs_x = int'(sx);
                    vs_y = int'(sy);
                end
            end
            prev_vs = svs;
        end
        chk("s.fs_period", 32'(period),  32'd240);
        chk("s.de_cnt",    32'(sde_cnt), 32'd96);
        chk("s.hs_cnt",    32'(shs_cnt), 32'd30);
        chk("s.vs_cnt",    32'(svs_cnt), 32'd48);
        chk("s.ls_cnt",    32'(sls_cnt), 32'd10);
        chk("s.vs_edge_x", 32'(vs_x),    32'd0);
        chk("s.vs_edge_y", 32'(vs_y),    32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
